cross_bar_req_alloc: RTL and testbench

Per-channel read-request allocator that sits directly upstream of the channel's reorder/return stage in the cross bar. It accepts one read request per cycle from the channel and selects the target bank from the address. It allocates a per-bank 3-bit ROB slot number and tracks per-bank and total outstanding credits. It then issues the tagged request to the bank and pulses the kickoff/bank-id pair that feeds the downstream keep-order FIFO. Credits are returned by the downstream per-bank sparse-write-buffer pop strobes.

---
 rtl/cross_bar_req_alloc_if.sv | 51 +++++
 rtl/cross_bar_req_alloc.sv | 136 +++++++++++++
 tb/tb_cross_bar_req_alloc.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cross_bar_req_alloc_if.sv
// Channel-side request, bank-side request and credit-return bundle
// for the cross bar read-request allocator.
interface cross_bar_req_alloc_if #(
    parameter int AW = 32
);
    logic          ch_req_valid_i;
    logic          ch_req_ready_o;
    logic [AW-1:0] ch_req_addr_i;

    logic [3:0]    xbar_req_valid_o;
    logic [3:0]    xbar_req_ready_i;
    logic [AW-1:0] xbar_req_addr_o;
    logic [1:0]    xbar_req_ch_id_o;
    logic [2:0]    xbar_req_rob_num_o;

    logic          kickoff_o;
    logic [1:0]    kickoff_bank_id_o;

    logic [3:0]    bank_spw_buffer_pop_i;
    logic          err_o;

    modport master (
        output ch_req_valid_i,
        input  ch_req_ready_o,
        output ch_req_addr_i,
        input  xbar_req_valid_o,
        output xbar_req_ready_i,
        input  xbar_req_addr_o,
        input  xbar_req_ch_id_o,
        input  xbar_req_rob_num_o,
        input  kickoff_o,
        input  kickoff_bank_id_o,
        output bank_spw_buffer_pop_i,
        input  err_o
    );

    modport slave (
        input  ch_req_valid_i,
        output ch_req_ready_o,
        input  ch_req_addr_i,
        output xbar_req_valid_o,
        input  xbar_req_ready_i,
        output xbar_req_addr_o,
        output xbar_req_ch_id_o,
        output xbar_req_rob_num_o,
        output kickoff_o,
        output kickoff_bank_id_o,
        input  bank_spw_buffer_pop_i,
        output err_o
    );
endinterface

// File: rtl/cross_bar_req_alloc.sv
// Per-channel read-request allocator: bank select, per-bank ROB slot
// allocation, credit tracking and keep-order FIFO kickoff.
module cross_bar_req_alloc #(
    parameter int CHANNEL_ID   = 0,
    parameter int AW           = 32,
    parameter int BANK_SEL_LSB = 4,
    parameter int KOF_DEPTH    = 16
) (
    input logic                   clk_i,
    input logic                   rst_n_i,
    cross_bar_req_alloc_if.slave  bus
);

    localparam int TW = $clog2(KOF_DEPTH + 1);
    localparam logic [3:0]    BANK_MAX = 4'd8;
    localparam logic [TW-1:0] TOT_MAX  = TW'(KOF_DEPTH);

    logic [3:0][3:0] bank_cnt_q, bank_cnt_d;
    logic [TW-1:0]   total_cnt_q, total_cnt_d;
    logic [3:0][2:0] alloc_ptr_q, alloc_ptr_d;

    logic            out_vld_q, out_vld_d;
    logic [1:0]      out_bank_q, out_bank_d;
    logic [AW-1:0]   out_addr_q, out_addr_d;
    logic [2:0]      out_rob_q, out_rob_d;

    logic            kick_q, kick_d;
    logic [1:0]      kick_bank_q, kick_bank_d;
    logic            err_q, err_d;

    logic [1:0]      bank;
    logic            out_free;
    logic            req_ready;
    logic            accept;
    logic [3:0]      acc_oh;
    logic [3:0]      pop;
    logic            pop_multi;
    logic [3:0]      pop_ok;
    logic            pop_err;

    assign bank = bus.ch_req_addr_i[BANK_SEL_LSB+1:BANK_SEL_LSB];
    assign pop  = bus.bank_spw_buffer_pop_i;

    // Output register may be reloaded when empty or draining this cycle
    assign out_free  = ~out_vld_q | bus.xbar_req_ready_i[out_bank_q];
    assign req_ready = out_free
                     & (bank_cnt_q[bank] != BANK_MAX)
                     & (total_cnt_q != TOT_MAX);
    assign accept    = bus.ch_req_valid_i & req_ready;
    assign acc_oh    = accept ? (4'b0001 << bank) : 4'b0000;
    assign pop_multi = (pop & (pop - 4'd1)) != 4'd0;

    always_comb begin
        pop_ok  = 4'b0000;
        pop_err = pop_multi;
        for (int b = 0; b < 4; b++) begin
            if (pop[b]) begin
                if (bank_cnt_q[b] == 4'd0) begin
                    pop_err = 1'b1;
                end else if (!pop_multi) begin
                    pop_ok[b] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        bank_cnt_d  = bank_cnt_q;
        alloc_ptr_d = alloc_ptr_q;
        for (int b = 0; b < 4; b++) begin
            bank_cnt_d[b] = bank_cnt_q[b]
                          + {3'd0, acc_oh[b]}
                          - {3'd0, pop_ok[b]};
            alloc_ptr_d[b] = alloc_ptr_q[b] + {2'd0, acc_oh[b]};
        end
        total_cnt_d = total_cnt_q
                    + TW'(accept)
                    - TW'(|pop_ok);
    end

    always_comb begin
        out_vld_d   = out_vld_q;
        out_bank_d  = out_bank_q;
        out_addr_d  = out_addr_q;
        out_rob_d   = out_rob_q;
        kick_d      = accept;
        kick_bank_d = kick_bank_q;
        err_d       = err_q | pop_err;
        if (accept) begin
            out_vld_d   = 1'b1;
            out_bank_d  = bank;
            out_addr_d  = bus.ch_req_addr_i;
            out_rob_d   = alloc_ptr_q[bank];
            kick_bank_d = bank;
        end else if (out_vld_q && bus.xbar_req_ready_i[out_bank_q]) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            bank_cnt_q  <= '0;
            total_cnt_q <= '0;
            alloc_ptr_q <= '0;
            out_vld_q   <= 1'b0;
            out_bank_q  <= 2'd0;
            out_addr_q  <= '0;
            out_rob_q   <= 3'd0;
            kick_q      <= 1'b0;
            kick_bank_q <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            bank_cnt_q  <= bank_cnt_d;
            total_cnt_q <= total_cnt_d;
            alloc_ptr_q <= alloc_ptr_d;
            out_vld_q   <= out_vld_d;
            out_bank_q  <= out_bank_d;
            out_addr_q  <= out_addr_d;
            out_rob_q   <= out_rob_d;
            kick_q      <= kick_d;
            kick_bank_q <= kick_bank_d;
            err_q       <= err_d;
        end
    end

    assign bus.ch_req_ready_o     = req_ready;
    assign bus.xbar_req_valid_o   = out_vld_q ? (4'b0001 << out_bank_q)
                                              : 4'b0000;
    assign bus.xbar_req_addr_o    = out_addr_q;
    assign bus.xbar_req_ch_id_o   = 2'(CHANNEL_ID);
    assign bus.xbar_req_rob_num_o = out_rob_q;
    assign bus.kickoff_o          = kick_q;
    assign bus.kickoff_bank_id_o  = kick_bank_q;
    assign bus.err_o              = err_q;

endmodule

// File: tb/tb_cross_bar_req_alloc.sv
// Directed bench for cross_bar_req_alloc: allocation, credit limits,
// back-pressure, same-cycle accept/pop, errors and mid-run reset.
module tb_cross_bar_req_alloc;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cnt;

    cross_bar_req_alloc_if #(.AW(32)) bus ();

    cross_bar_req_alloc #(
        .CHANNEL_ID(0),
        .AW(32),
        .BANK_SEL_LSB(4),
        .KOF_DEPTH(16)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Keep presenting addr; count accepts until ready drops (bounded)
    task automatic fill(input logic [31:0] addr, output int n);
        n = 0;
        bus.ch_req_valid_i = 1'b1;
        bus.ch_req_addr_i  = addr;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (!bus.ch_req_ready_o) break;
            step();
            n++;
        end
        bus.ch_req_valid_i = 1'b0;
    endtask

    initial begin
        bus.ch_req_valid_i        = 1'b0;
        bus.ch_req_addr_i         = '0;
        bus.xbar_req_ready_i      = 4'hF;
        bus.bank_spw_buffer_pop_i = 4'h0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.xbar_req_valid_o), 0);
        chk("rst_kick", 32'(bus.kickoff_o), 0);
        chk("rst_kbank", 32'(bus.kickoff_bank_id_o), 0);
        chk("rst_rob", 32'(bus.xbar_req_rob_num_o), 0);
        chk("rst_addr", bus.xbar_req_addr_o, 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_ready", 32'(bus.ch_req_ready_o), 1);
        chk("ch_id", 32'(bus.xbar_req_ch_id_o), 0);

        // Single request to bank 2
        bus.ch_req_valid_i = 1'b1;
        bus.ch_req_addr_i  = 32'h20;
        step();
        bus.ch_req_valid_i = 1'b0;
        chk("b2_valid", 32'(bus.xbar_req_valid_o), 32'h4);
        chk("b2_rob", 32'(bus.xbar_req_rob_num_o), 0);
        chk("b2_kick", 32'(bus.kickoff_o), 1);
        chk("b2_kbank", 32'(bus.kickoff_bank_id_o), 2);
        chk("b2_addr", bus.xbar_req_addr_o, 32'h20);
        step();
        chk("b2_drain", 32'(bus.xbar_req_valid_o), 0);
        chk("b2_kick_end", 32'(bus.kickoff_o), 0);
        bus.bank_spw_buffer_pop_i = 4'b0100;
        step();
        bus.bank_spw_buffer_pop_i = 4'h0;

        // Bank 0: eight slots then full, pop, wrap
        bus.ch_req_addr_i = 32'h0;
        for (int i = 0; i < 8; i++) begin
            bus.ch_req_valid_i = 1'b1;
            #1;
            chk("b0_ready", 32'(bus.ch_req_ready_o), 1);
            step();
            chk("b0_rob", 32'(bus.xbar_req_rob_num_o), 32'(i));
            chk("b0_valid", 32'(bus.xbar_req_valid_o), 1);
        end
        #1;
        chk("b0_full", 32'(bus.ch_req_ready_o), 0);
        step();
        chk("b0_full_nokick", 32'(bus.kickoff_o), 0);
        bus.bank_spw_buffer_pop_i = 4'b0001;
        #1;
        chk("b0_no_bypass", 32'(bus.ch_req_ready_o), 0);
        step();
        bus.bank_spw_buffer_pop_i = 4'h0;
        #1;
        chk("b0_reopen", 32'(bus.ch_req_ready_o), 1);
        step();
        bus.ch_req_valid_i = 1'b0;
        chk("b0_wrap_rob", 32'(bus.xbar_req_rob_num_o), 0);
        chk("b0_wrap_kick", 32'(bus.kickoff_o), 1);
        bus.bank_spw_buffer_pop_i = 4'b0001;
        for (int i = 0; i < 8; i++) step();
        bus.bank_spw_buffer_pop_i = 4'h0;

        // Total limit: 4 per bank
        cnt = 0;
        bus.ch_req_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.ch_req_addr_i = 32'((i % 4) << 4);
            #1;
            if (bus.ch_req_ready_o) cnt++;
            step();
        end
        bus.ch_req_valid_i = 1'b0;
        chk("tot_accepts", 32'(cnt), 16);
        for (int b = 0; b < 4; b++) begin
            bus.ch_req_addr_i = 32'(b << 4);
            #1;
            chk("tot_full", 32'(bus.ch_req_ready_o), 0);
        end
        bus.bank_spw_buffer_pop_i = 4'b1000;
        step();
        bus.bank_spw_buffer_pop_i = 4'h0;
        fill(32'h0, cnt);
        chk("tot_one_more", 32'(cnt), 1);
        // Drain: bank0 5, bank1 4, bank2 4, bank3 3
        bus.bank_spw_buffer_pop_i = 4'b0001;
        for (int i = 0; i < 5; i++) step();
        bus.bank_spw_buffer_pop_i = 4'b0010;
        for (int i = 0; i < 4; i++) step();
        bus.bank_spw_buffer_pop_i = 4'b0100;
        for (int i = 0; i < 4; i++) step();
        bus.bank_spw_buffer_pop_i = 4'b1000;
        for (int i = 0; i < 3; i++) step();
        bus.bank_spw_buffer_pop_i = 4'h0;

        // Back-pressure on bank 1 (slot 4 next)
        bus.xbar_req_ready_i = 4'b1101;
        bus.ch_req_valid_i   = 1'b1;
        bus.ch_req_addr_i    = 32'h10;
        step();
        bus.ch_req_addr_i = 32'h30;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_valid", 32'(bus.xbar_req_valid_o), 32'h2);
            chk("bp_rob", 32'(bus.xbar_req_rob_num_o), 4);
            chk("bp_addr", bus.xbar_req_addr_o, 32'h10);
            chk("bp_ready", 32'(bus.ch_req_ready_o), 0);
            step();
        end
        bus.xbar_req_ready_i = 4'hF;
        #1;
        chk("bp_release", 32'(bus.ch_req_ready_o), 1);
        step();
        bus.ch_req_valid_i = 1'b0;
        chk("b2b_valid", 32'(bus.xbar_req_valid_o), 32'h8);
        chk("b2b_rob", 32'(bus.xbar_req_rob_num_o), 4);
        chk("b2b_kbank", 32'(bus.kickoff_bank_id_o), 3);
        chk("b2b_addr", bus.xbar_req_addr_o, 32'h30);
        step();

        // Bank1 to 3 outstanding, then accept+pop same cycle
        bus.ch_req_valid_i = 1'b1;
        bus.ch_req_addr_i  = 32'h10;
        step();
        step();
        bus.bank_spw_buffer_pop_i = 4'b0010;
        #1;
        chk("ap_ready", 32'(bus.ch_req_ready_o), 1);
        step();
        bus.bank_spw_buffer_pop_i = 4'h0;
        bus.ch_req_valid_i = 1'b0;
        chk("ap_rob", 32'(bus.xbar_req_rob_num_o), 7);
        fill(32'h10, cnt);
        chk("ap_bank1_room", 32'(cnt), 5);
        fill(32'h00, cnt);
        chk("ap_total_room", 32'(cnt), 7);
        chk("err_clear", 32'(bus.err_o), 0);
        bus.bank_spw_buffer_pop_i = 4'b0011;
        step();
        bus.bank_spw_buffer_pop_i = 4'h0;
        chk("err_set", 32'(bus.err_o), 1);
        step();
        step();
        chk("err_sticky", 32'(bus.err_o), 1);

        // Reset with request pending
        bus.bank_spw_buffer_pop_i = 4'b0001;
        step();
        bus.bank_spw_buffer_pop_i = 4'h0;
        bus.xbar_req_ready_i = 4'b1011;
        bus.ch_req_valid_i   = 1'b1;
        bus.ch_req_addr_i    = 32'h20;
        #1;
        chk("pre_rst_ready", 32'(bus.ch_req_ready_o), 1);
        step();
        bus.ch_req_valid_i = 1'b0;
        chk("pre_rst_valid", 32'(bus.xbar_req_valid_o), 32'h4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.xbar_req_ready_i = 4'hF;
        #1;
        chk("mrst_valid", 32'(bus.xbar_req_valid_o), 0);
        chk("mrst_kick", 32'(bus.kickoff_o), 0);
        chk("mrst_kbank", 32'(bus.kickoff_bank_id_o), 0);
        chk("mrst_rob", 32'(bus.xbar_req_rob_num_o), 0);
        chk("mrst_addr", bus.xbar_req_addr_o, 0);
        chk("mrst_err", 32'(bus.err_o), 0);
        bus.ch_req_addr_i = 32'h10;
        #1;
        chk("mrst_b1_ready", 32'(bus.ch_req_ready_o), 1);
        bus.ch_req_valid_i = 1'b1;
        bus.ch_req_addr_i  = 32'h20;
        step();
        bus.ch_req_valid_i = 1'b0;
        chk("post_rst_rob", 32'(bus.xbar_req_rob_num_o), 0);
        chk("post_rst_kick", 32'(bus.kickoff_o), 1);
        chk("post_rst_kbank", 32'(bus.kickoff_bank_id_o), 2);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
